// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter that shares one word-addressed memory port
//            between NUM_REQ cache controllers. The grant is held for the whole
//            burst, and an optional beat limit hands the port to a waiting peer.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]            ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_ready
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_IDX_W:0]   c_NUM_EXT  = (c_IDX_W+1)'(NUM_REQ);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_BEATS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_beat_cnt;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic [c_IDX_W-1:0]    w_sel;
    logic [c_IDX_W:0]      w_idx;
    logic                  w_found;
    logic                  w_own_req;
    logic                  w_others;
    logic                  w_beat;
    logic                  w_limit_hit;
    logic                  w_preempt;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign w_addr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign rdata_o     = mem_rdata;
    assign w_owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_own_req   = req_i[r_owner];
    assign w_others    = |(req_i & ~w_owner_oh);
    assign w_beat      = (r_state == S_OWN) && w_own_req && mem_ready;
    assign w_limit_hit = (({1'b0, r_beat_cnt} + {{c_CNT_W{1'b0}}, 1'b1}) == {1'b0, c_MAX_CNT});
    // Preemption only lands on a completed beat, so no transfer is ever cut short.
    assign w_preempt   = (MAX_BEATS != 0) && w_beat && w_limit_hit && w_others;

    // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(i);
            if (w_idx >= c_NUM_EXT) begin
                w_idx = w_idx - c_NUM_EXT;
            end
            if (!w_found && req_i[w_idx[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ready_o     = '0;
        grant_o     = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                grant_o = w_owner_oh;
                busy    = 1'b1;
                mem_req = w_own_req;
                if (w_own_req) begin
                    mem_we    = we_i[r_owner];
                    mem_addr  = w_addr[r_owner];
                    mem_wdata = w_wdata[r_owner];
                    ready_o   = mem_ready ? w_owner_oh : '0;
                end
                if (!w_own_req || w_preempt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_sel;
                        r_beat_cnt <= '0;
                    end
                end
                S_OWN: begin
                    if (w_beat && (r_beat_cnt != c_MAX_CNT)) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_state_nxt == S_IDLE) begin
                        r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed bench for mem_arbiter: one instance with a 4-beat limit,
//            one with the limit disabled, driven by hand-timed stimulus.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req4;
    logic [1:0]  req_z;
    logic [1:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] rdata4, rdataz;
    logic [1:0]  ready4, readyz, grant4, grantz;
    logic        busy4, busyz, mreq4, mreqz, mwe4, mwez;
    logic [31:0] maddr4, maddrz, mwdata4, mwdataz;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_g4 [18];
    logic [1:0] exp_r4 [18];
    logic [1:0] exp_gz [18];
    logic [1:0] exp_rz [18];

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .req_i(req4), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata4), .ready_o(ready4), .grant_o(grant4), .busy(busy4),
        .mem_req(mreq4), .mem_we(mwe4), .mem_addr(maddr4), .mem_wdata(mwdata4),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BEATS(0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req_z), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdataz), .ready_o(readyz), .grant_o(grantz), .busy(busyz),
        .mem_req(mreqz), .mem_we(mwez), .mem_addr(maddrz), .mem_wdata(mwdataz),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req4 = '0; req_z = '0; we = '0; addr = '0; wdata = '0;
        mem_rdata = 32'h1234; mem_ready = 1'b0;
        #2;
        check("rst_grant", grant4, 2'b00);
        check("rst_busy", busy4, 1'b0);
        check("rst_mem_req", mreq4, 1'b0);
        check("rst_rdata_pass", rdata4, 32'h1234);
        cyc(); cyc();
        rst = 1'b0;

        // Single requester read burst
        cyc();
        req4 = 2'b01; addr[31:0] = 32'h40; settle();
        check("burst_pre_mem_req", mreq4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            addr[31:0] = 32'h40 + i; mem_ready = 1'b1; mem_rdata = 32'hA0 + i; settle();
            check("burst_mem_req", mreq4, 1'b1);
            check("burst_addr", maddr4, 32'h40 + i);
            check("burst_ready", ready4, 2'b01);
            check("burst_rdata", rdata4, 32'hA0 + i);
        end
        cyc();
        req4 = 2'b00; mem_ready = 1'b0; settle();
        check("release_mem_req", mreq4, 1'b0);
        cyc();
        check("release_grant", grant4, 2'b00);
        check("release_busy", busy4, 1'b0);
        // pointer advanced to 1: simultaneous request goes to requester 1
        req4 = 2'b11; settle();
        cyc();
        check("rr_after_burst", grant4, 2'b10);
        req4 = 2'b01; settle();
        check("rr_rel1_mem_req", mreq4, 1'b0);
        cyc();
        check("rr_turnaround", grant4, 2'b00);
        cyc();
        check("rr_then0", grant4, 2'b01);
        req4 = 2'b00;
        cyc();

        // Simultaneous requests from reset
        rst = 1'b1; settle();
        cyc();
        rst = 1'b0; req4 = 2'b11;
        cyc();
        check("simul_first", grant4, 2'b01);
        check("simul_mem_req", mreq4, 1'b1);
        req4 = 2'b10; settle();
        check("simul_drop0", mreq4, 1'b0);
        cyc();
        check("simul_idle_grant", grant4, 2'b00);
        check("simul_idle_req", mreq4, 1'b0);
        cyc();
        check("simul_second", grant4, 2'b10);
        req4 = 2'b00;
        cyc();
        req4 = 2'b11;
        cyc();
        check("simul_rr_back0", grant4, 2'b01);
        req4 = 2'b00;
        cyc(); cyc();

        // Write passthrough from requester 1 (pointer is 1 now)
        req4 = 2'b10; we = 2'b10;
        addr  = {32'h0000_0100, 32'h0000_0055};
        wdata = {32'hDEAD_BEEF, 32'h1111_1111};
        settle();
        check("wr_idle_addr", maddr4, 32'h0);
        cyc();
        check("wr_grant", grant4, 2'b10);
        check("wr_we", mwe4, 1'b1);
        check("wr_addr", maddr4, 32'h100);
        check("wr_wdata", mwdata4, 32'hDEADBEEF);
        req4 = 2'b11; addr[31:0] = 32'h77; wdata[31:0] = 32'h2222_2222; we = 2'b11;
        mem_ready = 1'b1; settle();
        check("wr_ignore_grant", grant4, 2'b10);
        check("wr_ignore_addr", maddr4, 32'h100);
        check("wr_ignore_wdata", mwdata4, 32'hDEADBEEF);
        check("wr_ready", ready4, 2'b10);
        cyc();
        req4 = 2'b01; mem_ready = 1'b0; we = 2'b00; settle();
        check("wr_rel_we", mwe4, 1'b0);
        check("wr_rel_addr", maddr4, 32'h0);
        cyc();
        check("wr_turnaround", grant4, 2'b00);
        cyc();
        check("wr_next0", grant4, 2'b01);
        req4 = 2'b00;
        cyc();

        // Preemption (limit 4) vs. no limit
        rst = 1'b1; settle();
        cyc();
        rst = 1'b0;
        exp_g4 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                   2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_r4 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                   2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        exp_gz = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                   2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        exp_rz = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                   2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        mem_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) cyc();
            req4  = {c <= 7,  c <= 15};
            req_z = {c <= 13, c <= 10};
            settle();
            check($sformatf("pre4_grant_c%0d", c), grant4, exp_g4[c]);
            check($sformatf("pre4_ready_c%0d", c), ready4, exp_r4[c]);
            check($sformatf("nolim_grant_c%0d", c), grantz, exp_gz[c]);
            check($sformatf("nolim_ready_c%0d", c), readyz, exp_rz[c]);
        end
        req4 = 2'b00; req_z = 2'b00; mem_ready = 1'b0;
        cyc(); cyc();

        // Reset mid-burst
        req4 = 2'b01; mem_ready = 1'b1;
        cyc();
        check("rstmid_beat1", ready4, 2'b01);
        cyc();
        check("rstmid_beat2", ready4, 2'b01);
        rst = 1'b1; settle();
        check("rstmid_mem_req", mreq4, 1'b0);
        check("rstmid_grant", grant4, 2'b00);
        check("rstmid_ready", ready4, 2'b00);
        check("rstmid_busy", busy4, 1'b0);
        cyc();
        rst = 1'b0; req4 = 2'b10; settle();
        check("rstmid_after_idle", grant4, 2'b00);
        cyc();
        check("rstmid_grant1", grant4, 2'b10);
        check("rstmid_mem_req1", mreq4, 1'b1);
        req4 = 2'b00; mem_ready = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
